prom_loader_512x8: RTL and testbench

Runtime loader and read port for the 512x8 address-decoder PROM image. It accepts a 512-byte image as a valid/ready byte stream, for example from the flash or host-link unpacker, and writes it sequentially into internal RAM. It checks an 8-bit additive checksum and then serves synchronous reads to the decode logic on the same port shape as the existing decoder PROM. This lets the board swap decoder images without resynthesis.

---
 rtl/prom_loader_512x8_pkg.sv | 23 ++
 rtl/prom_loader_512x8_if.sv | 29 ++
 rtl/prom_loader_512x8_ram_512x8_sdp.sv | 33 +++
 rtl/prom_loader_512x8.sv | 103 ++++++++++
 tb/tb_prom_loader_512x8.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/prom_loader_512x8_pkg.sv
// Shared constants for the 512x8 decoder PROM loader and its PROM wrappers:
// image geometry and the loader FSM state encoding.
package prom_loader_512x8_pkg;

  localparam int PROM_DEPTH      = 512;
  localparam int PROM_ADDR_WIDTH = 9;
  localparam int PROM_DATA_WIDTH = 8;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_LOAD  = 3'd1;
  localparam logic [2:0] STATE_CHECK = 3'd2;
  localparam logic [2:0] STATE_DONE  = 3'd3;
  localparam logic [2:0] STATE_ERROR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = STATE_IDLE,
    ST_LOAD  = STATE_LOAD,
    ST_CHECK = STATE_CHECK,
    ST_DONE  = STATE_DONE,
    ST_ERROR = STATE_ERROR
  } state_t;

endpackage

// File: rtl/prom_loader_512x8_if.sv
// Loader control/stream signals plus the decoder-side read port, bundled so
// the image source and the decode logic share one connection point.
interface prom_loader_512x8_if #(
  parameter int ADDR_WIDTH = prom_loader_512x8_pkg::PROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = prom_loader_512x8_pkg::PROM_DATA_WIDTH
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] expected_sum_i;
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [ADDR_WIDTH:0]   byte_count_o;
  logic                  clock_enable_i;
  logic [ADDR_WIDTH-1:0] address_i;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    output start_i, expected_sum_i, in_valid_i, in_data_i, clock_enable_i, address_i,
    input  in_ready_o, busy_o, done_o, error_o, byte_count_o, data_o
  );

  modport slave (
    input  start_i, expected_sum_i, in_valid_i, in_data_i, clock_enable_i, address_i,
    output in_ready_o, busy_o, done_o, error_o, byte_count_o, data_o
  );
endinterface

// File: rtl/prom_loader_512x8_ram_512x8_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with clock
// enable; a colliding read returns the contents from before the write.
module ram_512x8_sdp #(
  parameter int DEPTH      = prom_loader_512x8_pkg::PROM_DEPTH,
  parameter int ADDR_WIDTH = prom_loader_512x8_pkg::PROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = prom_loader_512x8_pkg::PROM_DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output
  // register is reset, which block RAM output latches support.
  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking reads sample mem before this edge's write lands,
  // which is exactly the read-before-write collision behaviour.
  always_ff @(posedge clock_i) begin
    if (reset_i)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/prom_loader_512x8.sv
// Runtime loader for the decoder PROM image: streams DEPTH bytes into RAM,
// verifies an additive checksum, and serves registered reads at all times.
module prom_loader_512x8
  import prom_loader_512x8_pkg::*;
#(
  parameter int DEPTH      = PROM_DEPTH,
  parameter int ADDR_WIDTH = PROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = PROM_DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  prom_loader_512x8_if.slave    bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] exp_sum;
  logic [ADDR_WIDTH:0]   count;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  accept;

  // ready is only ever set in LOAD, so it alone qualifies a write.
  assign accept = bus.in_valid_i & ready;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      sum     <= '0;
      exp_sum <= '0;
      count   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start_i) begin
            state   <= ST_LOAD;
            ptr     <= '0;
            sum     <= '0;
            count   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            exp_sum <= bus.expected_sum_i;
            ready   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            ptr   <= ptr + 1'b1;
            sum   <= sum + bus.in_data_i;
            count <= count + 1'b1;
            // Drop ready on the last accept so a 513th byte is never taken.
            if (count == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
              ready <= 1'b0;
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (sum == exp_sum) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.error_o      = error;
  assign bus.byte_count_o = count;

  ram_512x8_sdp #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we      (accept),
    .waddr   (ptr),
    .wdata   (bus.in_data_i),
    .re      (bus.clock_enable_i),
    .raddr   (bus.address_i),
    .rdata   (bus.data_o)
  );

endmodule

// File: tb/tb_prom_loader_512x8.sv
// Directed bench for prom_loader_512x8: loads, checksum pass/fail, stalls,
// mid-load reset, read collision and start_i filtering.
module tb_prom_loader_512x8;

  logic clk = 1'b0;
  logic reset_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prom_loader_512x8_if bus ();

  prom_loader_512x8 dut (
    .clock_i (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int mode, input int k);
    logic [31:0] kk;
    kk = k;
    case (mode)
      0:       return kk[7:0];
      1:       return 8'hA5;
      default: return (k == 7) ? 8'h3C : 8'hA5;
    endcase
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] sum);
    bus.start_i        = 1'b1;
    bus.expected_sum_i = sum;
    tick();
    bus.start_i        = 1'b0;
    check("start_ready", 32'(bus.in_ready_o), 32'd1);
    check("start_busy", 32'(bus.busy_o), 32'd1);
    check("start_count", 32'(bus.byte_count_o), 32'd0);
    check("start_done", 32'(bus.done_o), 32'd0);
    check("start_error", 32'(bus.error_o), 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    bus.clock_enable_i = 1'b1;
    bus.address_i      = addr;
    tick();
    bus.clock_enable_i = 1'b0;
    check(tag, 32'(bus.data_o), 32'(exp));
  endtask

  // Streams bytes until stop_after accepts, then (for a full image) checks the
  // CHECK cycle and final flags. Optional start_i pulses and a read collision.
  task automatic load_image(input int mode, input bit stall, input int start_at,
                            input bit start_in_check, input bit peek,
                            input logic [7:0] peek_old, input int stop_after,
                            input bit exp_done);
    int   acc    = 0;
    int   cycles = 0;
    logic rdy;
    bit   peeked;
    while (acc < stop_after && cycles < 5000) begin
      bus.in_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data_i  = pat(mode, acc);
      bus.start_i    = (acc == start_at);
      rdy            = bus.in_ready_o;
      peeked         = peek && acc == 7 && bus.in_valid_i && rdy;
      if (peeked) begin
        bus.clock_enable_i = 1'b1;
        bus.address_i      = 9'd7;
      end
      tick();
      cycles++;
      bus.start_i = 1'b0;
      if (peeked) begin
        bus.clock_enable_i = 1'b0;
        check("collision_old", 32'(bus.data_o), 32'(peek_old));
      end
      if (bus.in_valid_i && rdy) acc++;
    end
    bus.in_valid_i = 1'b0;
    check("accepted", 32'(acc), 32'(stop_after));
    if (stop_after == 512) begin
      if (!stall) check("full_rate_cycles", 32'(cycles), 32'd512);
      check("count_512", 32'(bus.byte_count_o), 32'd512);
      check("check_ready", 32'(bus.in_ready_o), 32'd0);
      check("check_busy", 32'(bus.busy_o), 32'd1);
      // Offer a 513th byte (and maybe start_i) during the CHECK cycle.
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 8'hEE;
      bus.start_i    = start_in_check;
      tick();
      bus.in_valid_i = 1'b0;
      bus.start_i    = 1'b0;
      check("final_count", 32'(bus.byte_count_o), 32'd512);
      check("final_done", 32'(bus.done_o), 32'(exp_done));
      check("final_error", 32'(bus.error_o), 32'(!exp_done));
      check("final_busy", 32'(bus.busy_o), 32'd0);
      check("final_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
      check("idle_ready", 32'(bus.in_ready_o), 32'd0);
    end
  endtask

  initial begin
    reset_i            = 1'b1;
    bus.start_i        = 1'b0;
    bus.expected_sum_i = 8'h00;
    bus.in_valid_i     = 1'b0;
    bus.in_data_i      = 8'h00;
    bus.clock_enable_i = 1'b0;
    bus.address_i      = 9'd0;

    // Reset values.
    do_reset();
    check("rst_ready", 32'(bus.in_ready_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_error", 32'(bus.error_o), 32'd0);
    check("rst_count", 32'(bus.byte_count_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);

    // Ramp image k&0xFF, sum 0x00, full rate.
    pulse_start(8'h00);
    load_image(0, 1'b0, -1, 1'b0, 1'b0, 8'h00, 512, 1'b1);
    read_check("rd_0", 9'd0, 8'h00);
    read_check("rd_255", 9'd255, 8'hFF);
    read_check("rd_511", 9'd511, 8'hFF);
    tick();
    check("rd_hold", 32'(bus.data_o), 32'hFF);

    // Start from DONE with wrong sum; start_i also pulsed in LOAD and CHECK.
    pulse_start(8'h01);
    load_image(0, 1'b0, 10, 1'b1, 1'b0, 8'h00, 512, 1'b0);
    read_check("err_rd_128", 9'd128, 8'h80);
    read_check("err_rd_3", 9'd3, 8'h03);

    // Random valid stalls, same ramp image.
    pulse_start(8'h00);
    load_image(0, 1'b1, -1, 1'b0, 1'b0, 8'h00, 512, 1'b1);
    read_check("stall_rd_1", 9'd1, 8'h01);
    read_check("stall_rd_300", 9'd300, 8'h2C);
    read_check("stall_rd_511", 9'd511, 8'hFF);

    // Reset after 100 bytes, then reload all 0xA5.
    pulse_start(8'h00);
    load_image(1, 1'b0, -1, 1'b0, 1'b0, 8'h00, 100, 1'b0);
    do_reset();
    check("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    check("mid_rst_count", 32'(bus.byte_count_o), 32'd0);
    pulse_start(8'h00);
    load_image(1, 1'b0, -1, 1'b0, 1'b0, 8'h00, 512, 1'b1);
    for (int a = 0; a < 512; a++) read_check("a5_rd", 9'(a), 8'hA5);

    // Collision at address 7: old 0xA5 seen, then 0x3C. Sum 511*A5+3C = 0x97.
    pulse_start(8'h97);
    load_image(2, 1'b0, -1, 1'b0, 1'b1, 8'hA5, 512, 1'b1);
    read_check("collision_new", 9'd7, 8'h3C);
    read_check("collision_nbr", 9'd8, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
